// File: rtl/obstacle_track_engine_pkg.sv
// Package: obstacle_track_engine_pkg
// Purpose: shared encodings for the obstacle track engine.
//   state_e    : game FSM states (ST_IDLE/ST_RUN/ST_OVER), also the state output encoding.
//   OBS_*      : obstacle type codes; 0 is always an empty cell.
// Optional feature macro used elsewhere in this slice: DUCK_EN.
package obstacle_track_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int unsigned OBS_EMPTY = 0;
  localparam int unsigned OBS_LOW   = 1;
  localparam int unsigned OBS_HIGH  = 2;

endpackage

// File: rtl/obstacle_track_engine_if.sv
// Interface: obstacle_track_engine_if
// Purpose: bundles the game-control inputs and game-state outputs of obstacle_track_engine.
// Signals (master = controller/testbench side, slave = engine side):
//   shift_enable, jump_trigger, start_game, force_game_over, rand_val[15:0]  master -> slave
//   duck_hold (only when DUCK_EN is defined)                                 master -> slave
//   state[1:0], game_over, dino_on_ground, hit_type, score, obstacle_map_flat slave -> master
interface obstacle_track_engine_if #(
  parameter int unsigned TRACK_LEN = 16,
  parameter int unsigned TYPE_W    = 2,
  parameter int unsigned SCORE_W   = 32
);
  logic                        shift_enable;
  logic                        jump_trigger;
  logic                        start_game;
  logic                        force_game_over;
  logic [15:0]                 rand_val;
`ifdef DUCK_EN
  logic                        duck_hold;
`endif
  logic [1:0]                  state;
  logic                        game_over;
  logic                        dino_on_ground;
  logic [TYPE_W-1:0]           hit_type;
  logic [SCORE_W-1:0]          score;
  logic [TRACK_LEN*TYPE_W-1:0] obstacle_map_flat;

  modport master (
`ifdef DUCK_EN
    output duck_hold,
`endif
    output shift_enable, jump_trigger, start_game, force_game_over, rand_val,
    input  state, game_over, dino_on_ground, hit_type, score, obstacle_map_flat
  );

  modport slave (
`ifdef DUCK_EN
    input  duck_hold,
`endif
    input  shift_enable, jump_trigger, start_game, force_game_over, rand_val,
    output state, game_over, dino_on_ground, hit_type, score, obstacle_map_flat
  );
endinterface

// File: rtl/obstacle_track_engine_jump_ctrl.sv
// Module: obstacle_track_engine_jump_ctrl
// Purpose: dino vertical state: buffered jump request, airtime counter, grounded flag.
// Ports:
//   CLK, RST     clock, async active-high reset
//   i_clear      start/restart: drop request, ground the dino
//   i_tick       raw game tick (consumes any buffered request)
//   i_run        game is running (jump requests are buffered only then)
//   i_step       advance the jump/airtime state this tick
//   i_jump       jump request pulse
//   o_on_ground  1 = dino grounded (registered)
module obstacle_track_engine_jump_ctrl #(
  parameter int unsigned JUMP_TICKS = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clear,
  input  logic i_tick,
  input  logic i_run,
  input  logic i_step,
  input  logic i_jump,
  output logic o_on_ground
);
  localparam int unsigned CntW = $clog2(JUMP_TICKS + 1);

  logic            r_jump_pend, w_jump_pend_next;
  logic            r_on_ground, w_on_ground_next;
  logic [CntW-1:0] r_air_cnt, w_air_cnt_next;
  logic            w_jump_eff;

  // A request between ticks is held so it still counts on the next tick.
  assign w_jump_eff = i_jump | r_jump_pend;

  always_comb begin
    w_jump_pend_next = r_jump_pend;
    w_on_ground_next = r_on_ground;
    w_air_cnt_next   = r_air_cnt;
    if (i_clear) begin
      w_jump_pend_next = 1'b0;
      w_on_ground_next = 1'b1;
      w_air_cnt_next   = '0;
    end else begin
      if (i_tick) begin
        w_jump_pend_next = 1'b0;
      end else if (i_run && i_jump) begin
        w_jump_pend_next = 1'b1;
      end
      if (i_step) begin
        if (r_on_ground) begin
          if (w_jump_eff) begin
            w_on_ground_next = 1'b0;
            w_air_cnt_next   = CntW'(JUMP_TICKS);
          end
        end else if (r_air_cnt != '0) begin
          w_air_cnt_next = r_air_cnt - 1'b1;
        end else begin
          w_on_ground_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_jump_pend <= 1'b0;
      r_on_ground <= 1'b1;
      r_air_cnt   <= '0;
    end else begin
      r_jump_pend <= w_jump_pend_next;
      r_on_ground <= w_on_ground_next;
      r_air_cnt   <= w_air_cnt_next;
    end
  end

  assign o_on_ground = r_on_ground;

endmodule

// File: rtl/obstacle_track_engine.sv
// Module: obstacle_track_engine
// Purpose: runner-game core. Shifting N-cell obstacle track with windowed random spawn,
//   IDLE/RUN/OVER game FSM, collision detection against the dino column (cell 0) and a
//   saturating tick score. Jump/airtime lives in obstacle_track_engine_jump_ctrl.
// Ports:
//   CLK, RST   clock, async active-high reset
//   bus        obstacle_track_engine_if.slave (controls in, registered game state out)
// Optional feature: DUCK_EN -- adds duck_hold; a grounded ducking dino ignores OBS_HIGH.
module obstacle_track_engine
  import obstacle_track_engine_pkg::*;
#(
  parameter int unsigned TRACK_LEN  = 16,
  parameter int unsigned TYPE_W     = 2,
  parameter int unsigned JUMP_TICKS = 2,
  parameter int unsigned SPAWN_GAP  = 11,
  parameter int unsigned SCORE_W    = 32,
  parameter int unsigned SCORE_MAX  = 100000000
) (
  input logic                    CLK,
  input logic                    RST,
  obstacle_track_engine_if.slave bus
);
  localparam int unsigned GapLo = TRACK_LEN - SPAWN_GAP;

  state_e             r_state, w_state_next;
  logic [TYPE_W-1:0]  r_cells [TRACK_LEN];
  logic [TYPE_W-1:0]  w_cells_next [TRACK_LEN];
  logic [TYPE_W-1:0]  r_hit_type, w_hit_next;
  logic [SCORE_W-1:0] r_score, w_score_next, w_score_inc;
  logic               r_game_over;
  logic               w_on_ground, w_tick_run, w_hit, w_duck_safe;
  logic               w_window_empty, w_spawn;
  logic [TYPE_W-1:0]  w_spawn_type;
  logic               w_unused_rand;

  assign w_unused_rand = ^bus.rand_val[15:2+TYPE_W];
  assign w_tick_run    = bus.shift_enable && (r_state == ST_RUN);

  always_comb begin
    w_window_empty = 1'b1;
    for (int unsigned i = GapLo; i < TRACK_LEN; i++) begin
      if (r_cells[i] != TYPE_W'(OBS_EMPTY)) w_window_empty = 1'b0;
    end
  end

  assign w_spawn      = w_window_empty && (bus.rand_val[1:0] != 2'b11);
  // A zero type draw would spawn nothing, so it is promoted to the low obstacle.
  assign w_spawn_type = (bus.rand_val[2+:TYPE_W] == '0) ? TYPE_W'(OBS_LOW)
                                                         : bus.rand_val[2+:TYPE_W];

`ifdef DUCK_EN
  assign w_duck_safe = bus.duck_hold && (r_cells[0] == TYPE_W'(OBS_HIGH));
`else
  assign w_duck_safe = 1'b0;
`endif
  // Airborne dino is never hit, so duck_hold only matters while grounded.
  assign w_hit = (r_cells[0] != TYPE_W'(OBS_EMPTY)) && w_on_ground && !w_duck_safe;

  assign w_score_inc = (r_score >= SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                        : r_score + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_hit_next   = r_hit_type;
    w_score_next = r_score;
    for (int unsigned i = 0; i < TRACK_LEN; i++) w_cells_next[i] = r_cells[i];
    if (bus.start_game) begin
      w_state_next = ST_RUN;
      w_hit_next   = '0;
      w_score_next = '0;
      for (int unsigned i = 0; i < TRACK_LEN; i++) w_cells_next[i] = '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.force_game_over) w_state_next = ST_OVER;
        ST_RUN: begin
          if (w_tick_run) begin
            for (int unsigned i = 0; i < TRACK_LEN - 1; i++) w_cells_next[i] = r_cells[i+1];
            w_cells_next[TRACK_LEN-1] = w_spawn ? w_spawn_type : '0;
            // The collision tick still shifts but does not score.
            if (w_hit) begin
              w_state_next = ST_OVER;
              w_hit_next   = r_cells[0];
            end else begin
              w_score_next = w_score_inc;
              if (w_score_inc == SCORE_W'(SCORE_MAX)) w_state_next = ST_OVER;
            end
          end
          if (bus.force_game_over) w_state_next = ST_OVER;
        end
        ST_OVER: ;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_hit_type  <= '0;
      r_score     <= '0;
      r_game_over <= 1'b0;
      for (int unsigned i = 0; i < TRACK_LEN; i++) r_cells[i] <= '0;
    end else begin
      r_state     <= w_state_next;
      r_hit_type  <= w_hit_next;
      r_score     <= w_score_next;
      r_game_over <= (w_state_next == ST_OVER);
      for (int unsigned i = 0; i < TRACK_LEN; i++) r_cells[i] <= w_cells_next[i];
    end
  end

  obstacle_track_engine_jump_ctrl #(
    .JUMP_TICKS (JUMP_TICKS)
  ) u_jump_ctrl (
    .CLK         (CLK),
    .RST         (RST),
    .i_clear     (bus.start_game),
    .i_tick      (bus.shift_enable),
    .i_run       (r_state == ST_RUN),
    .i_step      (w_tick_run && !w_hit),
    .i_jump      (bus.jump_trigger),
    .o_on_ground (w_on_ground)
  );

  assign bus.state          = r_state;
  assign bus.game_over      = r_game_over;
  assign bus.dino_on_ground = w_on_ground;
  assign bus.hit_type       = r_hit_type;
  assign bus.score          = r_score;

  for (genvar g = 0; g < TRACK_LEN; g++) begin : g_map
    assign bus.obstacle_map_flat[TYPE_W*g +: TYPE_W] = r_cells[g];
  end

endmodule

// File: tb/tb_obstacle_track_engine.sv
// Testbench: tb_obstacle_track_engine
// Two engines share one stimulus stream: u_dut (default parameters) and u_dut_s
// (SCORE_MAX=5). Stimulus pushes expected snapshots into a queue; a monitor on the falling
// edge pops each one and compares it with the selected engine's outputs.
// Build with DUCK_EN defined to exercise the duck path.
module tb_obstacle_track_engine;

  typedef struct packed {
    logic        sel;
    logic [1:0]  st;
    logic        og;
    logic [1:0]  hit;
    logic [31:0] score;
    logic [31:0] map;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        shift_enable, jump_trigger, start_game, force_game_over, duck_hold;
  logic [15:0] rand_val;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  string nq[$];
  exp_t e;
  string n;

  always #5 clk = ~clk;

  obstacle_track_engine_if #(.TRACK_LEN(16), .TYPE_W(2), .SCORE_W(32)) if_d ();
  obstacle_track_engine_if #(.TRACK_LEN(16), .TYPE_W(2), .SCORE_W(32)) if_s ();

  assign if_d.shift_enable    = shift_enable;
  assign if_d.jump_trigger    = jump_trigger;
  assign if_d.start_game      = start_game;
  assign if_d.force_game_over = force_game_over;
  assign if_d.rand_val        = rand_val;
  assign if_s.shift_enable    = shift_enable;
  assign if_s.jump_trigger    = jump_trigger;
  assign if_s.start_game      = start_game;
  assign if_s.force_game_over = force_game_over;
  assign if_s.rand_val        = rand_val;
`ifdef DUCK_EN
  assign if_d.duck_hold       = duck_hold;
  assign if_s.duck_hold       = duck_hold;
`endif

  obstacle_track_engine u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (if_d)
  );

  obstacle_track_engine #(
    .SCORE_MAX (5)
  ) u_dut_s (
    .CLK (clk),
    .RST (rst),
    .bus (if_s)
  );

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
    end
  endtask

  // Monitor: drains all pending expectations away from the active edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      n = nq.pop_front();
      if (e.sel) begin
        chk(n, "state", 32'(if_s.state), 32'(e.st));
        chk(n, "game_over", 32'(if_s.game_over), 32'(e.st == 2'd2));
        chk(n, "on_ground", 32'(if_s.dino_on_ground), 32'(e.og));
        chk(n, "hit_type", 32'(if_s.hit_type), 32'(e.hit));
        chk(n, "score", if_s.score, e.score);
        chk(n, "map", if_s.obstacle_map_flat, e.map);
      end else begin
        chk(n, "state", 32'(if_d.state), 32'(e.st));
        chk(n, "game_over", 32'(if_d.game_over), 32'(e.st == 2'd2));
        chk(n, "on_ground", 32'(if_d.dino_on_ground), 32'(e.og));
        chk(n, "hit_type", 32'(if_d.hit_type), 32'(e.hit));
        chk(n, "score", if_d.score, e.score);
        chk(n, "map", if_d.obstacle_map_flat, e.map);
      end
    end
  end

  task automatic expect_st(input logic sel, input string nm, input logic [1:0] st,
                           input logic og, input logic [1:0] hit, input int unsigned sc,
                           input logic [31:0] mp);
    exp_t x;
    x.sel   = sel;
    x.st    = st;
    x.og    = og;
    x.hit   = hit;
    x.score = sc;
    x.map   = mp;
    q.push_back(x);
    nq.push_back(nm);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [15:0] rv);
    rand_val     = rv;
    shift_enable = 1'b1;
    cyc();
    shift_enable = 1'b0;
  endtask

  task automatic ticks(input int cnt, input logic [15:0] rv);
    for (int i = 0; i < cnt; i++) tick(rv);
  endtask

  task automatic pulse_start();
    start_game = 1'b1;
    cyc();
    start_game = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    shift_enable = 1'b0; jump_trigger = 1'b0; start_game = 1'b0;
    force_game_over = 1'b0; duck_hold = 1'b0; rand_val = 16'h0003;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_st(1'b0, "reset", 2'd0, 1'b1, 2'd0, 0, 32'h0);
    expect_st(1'b1, "reset_s", 2'd0, 1'b1, 2'd0, 0, 32'h0);
    ticks(3, 16'h0004);
    expect_st(1'b0, "idle_ticks", 2'd0, 1'b1, 2'd0, 0, 32'h0);
    expect_st(1'b1, "idle_ticks_s", 2'd0, 1'b1, 2'd0, 0, 32'h0);

    force_game_over = 1'b1; cyc(); force_game_over = 1'b0;
    expect_st(1'b0, "force_idle", 2'd2, 1'b1, 2'd0, 0, 32'h0);
    force_game_over = 1'b1; cyc(); force_game_over = 1'b0;
    expect_st(1'b0, "force_over", 2'd2, 1'b1, 2'd0, 0, 32'h0);

    // start beats a coincident abort
    start_game = 1'b1; force_game_over = 1'b1; cyc();
    start_game = 1'b0; force_game_over = 1'b0;
    expect_st(1'b0, "start_beats_force", 2'd1, 1'b1, 2'd0, 0, 32'h0);
    expect_st(1'b1, "start_beats_force_s", 2'd1, 1'b1, 2'd0, 0, 32'h0);
    ticks(20, 16'h0003);
    expect_st(1'b0, "no_spawn_20", 2'd1, 1'b1, 2'd0, 20, 32'h0);
    expect_st(1'b1, "score_max", 2'd2, 1'b1, 2'd0, 5, 32'h0);
    ticks(3, 16'h0003);
    expect_st(1'b0, "no_spawn_23", 2'd1, 1'b1, 2'd0, 23, 32'h0);
    expect_st(1'b1, "score_hold", 2'd2, 1'b1, 2'd0, 5, 32'h0);

    // collision with a low obstacle
    pulse_start();
    expect_st(1'b0, "restart", 2'd1, 1'b1, 2'd0, 0, 32'h0);
    tick(16'h0004);
    expect_st(1'b0, "spawn_low", 2'd1, 1'b1, 2'd0, 1, 32'h4000_0000);
    ticks(15, 16'h0003);
    expect_st(1'b0, "arrive", 2'd1, 1'b1, 2'd0, 16, 32'h0000_0001);
    tick(16'h0003);
    expect_st(1'b0, "collide", 2'd2, 1'b1, 2'd1, 16, 32'h0);
    ticks(2, 16'h0004);
    expect_st(1'b0, "frozen_over", 2'd2, 1'b1, 2'd1, 16, 32'h0);

    // buffered jump clears the obstacle
    pulse_start();
    expect_st(1'b0, "restart2", 2'd1, 1'b1, 2'd0, 0, 32'h0);
    tick(16'h0004);
    ticks(14, 16'h0003);
    expect_st(1'b0, "pre_jump", 2'd1, 1'b1, 2'd0, 15, 32'h0000_0004);
    jump_trigger = 1'b1; cyc(); jump_trigger = 1'b0;
    cyc(); cyc();
    tick(16'h0003);
    expect_st(1'b0, "takeoff", 2'd1, 1'b0, 2'd0, 16, 32'h0000_0001);
    tick(16'h0003);
    expect_st(1'b0, "air1", 2'd1, 1'b0, 2'd0, 17, 32'h0);
    tick(16'h0003);
    expect_st(1'b0, "air2", 2'd1, 1'b0, 2'd0, 18, 32'h0);
    tick(16'h0003);
    expect_st(1'b0, "land", 2'd1, 1'b1, 2'd0, 19, 32'h0);

    force_game_over = 1'b1; cyc(); force_game_over = 1'b0;
    expect_st(1'b0, "force_run", 2'd2, 1'b1, 2'd0, 19, 32'h0);

    pulse_start();
    tick(16'h0000);
    expect_st(1'b0, "zero_draw", 2'd1, 1'b1, 2'd0, 1, 32'h4000_0000);

    // high obstacle
    pulse_start();
    tick(16'h0008);
    expect_st(1'b0, "spawn_high", 2'd1, 1'b1, 2'd0, 1, 32'h8000_0000);
    ticks(15, 16'h0003);
    expect_st(1'b0, "arrive_high", 2'd1, 1'b1, 2'd0, 16, 32'h0000_0002);
`ifdef DUCK_EN
    duck_hold = 1'b1; tick(16'h0003); duck_hold = 1'b0;
    expect_st(1'b0, "duck_high", 2'd1, 1'b1, 2'd0, 17, 32'h0);
    pulse_start();
    tick(16'h0004);
    ticks(15, 16'h0003);
    duck_hold = 1'b1; tick(16'h0003); duck_hold = 1'b0;
    expect_st(1'b0, "duck_low", 2'd2, 1'b1, 2'd1, 16, 32'h0);
`else
    tick(16'h0003);
    expect_st(1'b0, "high_hit", 2'd2, 1'b1, 2'd2, 16, 32'h0);
`endif

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
